// File: rtl/spike_prebuf.sv
// Ping-pong frame buffer for 4-lane spike nibbles.
// Packs 144 nibbles into 18 words per bank; the consumer reads and releases banks.
module spike_prebuf #(
  parameter int N_WORD = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_w_run,
  input  logic        i_valid,
  input  logic [3:0]  i_spike,
  input  logic        i_rd_en,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_release,
  output logic [31:0] o_rd_data,
  output logic        o_rd_ready,
  output logic        o_frame_done,
  output logic [9:0]  o_spk_cnt,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE, FILL, COMMIT, DROP
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem [2][N_WORD];
  logic        wb, rb;
  logic [1:0]  full;
  logic [2:0]  nib;
  logic [4:0]  word_cnt;
  logic [31:0] shreg;
  logic [9:0]  run_cnt;

  logic [2:0]  pc;
  logic [31:0] word_nx;
  logic        last;
  logic        clr;
  logic        we;

  always_comb begin
    pc = {2'b00, i_spike[0]} + {2'b00, i_spike[1]}
       + {2'b00, i_spike[2]} + {2'b00, i_spike[3]};
    word_nx = shreg;
    word_nx[{nib, 2'b00} +: 4] = i_spike;
    last = i_valid && (nib == 3'd7)
        && (word_cnt == 5'(N_WORD - 1));
    clr = i_w_run
       && (state == IDLE || state == FILL);
    we = (state == FILL) && i_valid
      && !i_w_run && (nib == 3'd7);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_w_run)
          state_nx = full[wb] ? DROP : FILL;
      end
      FILL: begin
        if (i_w_run)   state_nx = FILL;
        else if (last) state_nx = COMMIT;
      end
      COMMIT: state_nx = IDLE;
      DROP: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state != IDLE);
    o_frame_done = (state == COMMIT);
  end

  assign o_rd_ready = full[rb];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib       <= '0;
      word_cnt  <= '0;
      shreg     <= '0;
      run_cnt   <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      full      <= '0;
      o_spk_cnt <= '0;
      o_err     <= 1'b0;
      o_rd_data <= '0;
    end else begin
      if (clr) begin
        nib      <= '0;
        word_cnt <= '0;
        shreg    <= '0;
        run_cnt  <= '0;
      end else if (i_valid &&
                   (state == FILL || state == DROP)) begin
        nib <= nib + 3'd1;
        if (nib == 3'd7)
          word_cnt <= word_cnt + 5'd1;
        if (state == FILL) begin
          shreg   <= (nib == 3'd7) ? '0 : word_nx;
          run_cnt <= run_cnt + {7'd0, pc};
        end
      end
      if (state == DROP || (i_w_run &&
          (state == FILL || state == COMMIT)))
        o_err <= 1'b1;
      // commit and release always target different banks
      if (state == COMMIT) begin
        full[wb]  <= 1'b1;
        wb        <= ~wb;
        o_spk_cnt <= run_cnt;
      end
      if (i_rd_release && full[rb]) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      if (i_rd_en) begin
        if (full[rb] && i_rd_addr < 5'(N_WORD))
          o_rd_data <= mem[rb][i_rd_addr];
        else
          o_rd_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wb][word_cnt] <= word_nx;
  end

endmodule

// File: tb/tb_spike_prebuf.sv
// Directed bench for spike_prebuf with a bank model
// and a read-data scoreboard queue.
module tb_spike_prebuf;

  localparam int NW = 18;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_w_run, i_valid, i_rd_en, i_rd_release;
  logic [3:0]  i_spike;
  logic [4:0]  i_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_ready, o_frame_done, o_busy, o_err;
  logic [9:0]  o_spk_cnt;

  spike_prebuf #(.N_WORD(NW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_w_run(i_w_run), .i_valid(i_valid),
    .i_spike(i_spike), .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr),
    .i_rd_release(i_rd_release),
    .o_rd_data(o_rd_data), .o_rd_ready(o_rd_ready),
    .o_frame_done(o_frame_done),
    .o_spk_cnt(o_spk_cnt), .o_busy(o_busy),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [31:0] m_bank [2][NW];
  bit          m_full [2];
  bit          m_wb, m_rb;
  logic [31:0] sb [$];
  logic [31:0] last_exp;

  always @(negedge clk)
    if (o_frame_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0;
    m_full[1] = 0;
    m_wb = 0;
    m_rb = 0;
    sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"}, o_rd_data, 0);
    chk({tag, "_rd_ready"}, 32'(o_rd_ready), 0);
    chk({tag, "_done"}, 32'(o_frame_done), 0);
    chk({tag, "_spk_cnt"}, 32'(o_spk_cnt), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  task automatic rd(input int a);
    logic [31:0] e;
    i_rd_en = 1'b1;
    i_rd_addr = 5'(a);
    e = 32'h0;
    if (m_full[m_rb] && a < NW) e = m_bank[m_rb][a];
    sb.push_back(e);
    tick();
    i_rd_en = 1'b0;
    last_exp = sb.pop_front();
    chk($sformatf("rd_data[%0d]", a), o_rd_data, last_exp);
  endtask

  task automatic release_bank();
    i_rd_release = 1'b1;
    tick();
    i_rd_release = 1'b0;
    if (m_full[m_rb]) begin
      m_full[m_rb] = 0;
      m_rb = ~m_rb;
    end
    chk("rd_ready_rel", 32'(o_rd_ready), 32'(m_full[m_rb]));
  endtask

  task automatic partial(input int n);
    i_w_run = 1'b1;
    tick();
    i_w_run = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_spike = 4'($urandom_range(0, 15));
      tick();
    end
    i_valid = 1'b0;
  endtask

  // mode 0: all ones, 1: 1..8 per word, 2: random
  task automatic do_frame(input int mode,
                          input bit commit,
                          input bit rel);
    logic [31:0] w [NW];
    logic [3:0]  nb;
    int          cnt;
    int          d0;
    bit          rel_ok;
    cnt = 0;
    d0 = done_cnt;
    for (int i = 0; i < NW; i++) w[i] = 32'h0;
    i_w_run = 1'b1;
    tick();
    i_w_run = 1'b0;
    for (int k = 0; k < 144; k++) begin
      if (mode == 0)      nb = 4'hF;
      else if (mode == 1) nb = 4'((k % 8) + 1);
      else                nb = 4'($urandom_range(0, 15));
      w[k / 8][4 * (k % 8) +: 4] = nb;
      cnt += $countones(nb);
      i_valid = 1'b1;
      i_spike = nb;
      tick();
      if (k == 0) chk("busy", 32'(o_busy), 1);
    end
    i_valid = 1'b0;
    if (commit) begin
      chk("frame_done", 32'(o_frame_done), 1);
      i_rd_release = rel;
      tick();
      i_rd_release = 1'b0;
      rel_ok = rel && m_full[m_rb];
      for (int i = 0; i < NW; i++) m_bank[m_wb][i] = w[i];
      m_full[m_wb] = 1;
      m_wb = ~m_wb;
      if (rel_ok) begin
        m_full[m_rb] = 0;
        m_rb = ~m_rb;
      end
      chk("done_count", 32'(done_cnt), 32'(d0 + 1));
      chk("spk_cnt", 32'(o_spk_cnt), 32'(cnt));
      chk("rd_ready", 32'(o_rd_ready), 32'(m_full[m_rb]));
    end else begin
      chk("drop_done", 32'(o_frame_done), 0);
      chk("drop_err", 32'(o_err), 1);
      chk("drop_busy", 32'(o_busy), 0);
      tick();
      chk("drop_done_cnt", 32'(done_cnt), 32'(d0));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    model_reset();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    i_w_run = 0; i_valid = 0; i_spike = 0;
    i_rd_en = 0; i_rd_addr = 0; i_rd_release = 0;
    last_exp = 0;
    do_reset();

    // single all-ones frame into bank 0
    do_frame(0, 1, 0);
    chk("spk_576", 32'(o_spk_cnt), 576);
    for (int a = 0; a < NW; a++) rd(a);

    // packing frame into bank 1, then a dropped third frame
    do_frame(1, 1, 0);
    chk("spk_234", 32'(o_spk_cnt), 234);
    do_frame(2, 0, 0);
    chk("rd_ready_drop", 32'(o_rd_ready), 1);
    rd(5);
    release_bank();
    rd(0);
    chk("pack_word0", o_rd_data, 32'h87654321);
    tick();
    chk("rd_hold", o_rd_data, last_exp);
    rd(18);
    rd(17);
    rd(31);
    release_bank();
    rd(3);
    chk("err_sticky", 32'(o_err), 1);

    // restart mid-frame
    do_reset();
    partial(50);
    do_frame(2, 1, 0);
    chk("restart_err", 32'(o_err), 1);
    rd(0);
    rd(9);

    // release coinciding with commit
    do_frame(2, 1, 1);
    rd(0);
    rd(17);
    release_bank();
    rd(1);

    // reset mid-FILL
    partial(70);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 20; i++) tick();
      chk("mid_reset_nodone", 32'(done_cnt), 32'(d0));
    end
    do_frame(2, 1, 0);
    rd(0);
    rd(11);
    chk("final_err", 32'(o_err), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/spike_prebuf.md
SPIKE_PREBUF -- requirements
Module: spike_prebuf

Interface
REQ-001 Parameter: N_WORD, 18, 32-bit words per frame (144 spike cycles x 4 bits = 576 bits).
REQ-002 Ports, one per line, SHALL be:
  clk  in  1  sole clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  i_w_run  in  1  frame-start pulse, one cycle before the first i_valid of the frame
  i_valid  in  1  i_spike is valid this cycle
  i_spike  in  4  spike nibble (bit n = pixel lane n)
  i_rd_en  in  1  read strobe on the ready bank
  i_rd_addr  in  5  word address within the ready bank
  i_rd_release  in  1  pulse: consumer has finished the ready bank
  o_rd_data  out  32  registered read data
  o_rd_ready  out  1  read bank holds a complete frame
  o_frame_done  out  1  one-cycle pulse when a frame is committed
  o_spk_cnt  out  10  number of 1-bits in the last committed frame
  o_busy  out  1  frame capture in progress
  o_err  out  1  sticky error flag
REQ-003 Clock and reset SHALL be exactly one clock and one asynchronous, active-low reset (clk, reset_n).

Function
REQ-004 Storage SHALL be two banks (ping-pong) of N_WORD x 32 bits, with write pointer wb, read pointer rb and per-bank full flags.
REQ-005 FSM states SHALL be IDLE, FILL, COMMIT and DROP.
REQ-006 IDLE SHALL go to FILL on i_w_run if full[wb]=0, and to DROP otherwise; in IDLE, i_valid SHALL be ignored.
REQ-007 On the i_w_run cycle, nibble counter, word counter, shift register and running spike count SHALL clear.
REQ-008 In FILL, each i_valid SHALL place i_spike at bits [4j+3:4j] of the word being built, where j is the nibble counter (0..7); j SHALL increment.
REQ-009 On the 8th nibble (j=7), the word SHALL be written to bank[wb][word_cnt] in the same cycle as the nibble is captured; j SHALL wrap to 0 and word_cnt SHALL increment.
REQ-010 The running spike count SHALL add popcount(i_spike) on every FILL i_valid, in 10-bit unsigned arithmetic (maximum 576, no saturation needed).
REQ-011 The write of word N_WORD-1 SHALL move the FSM to COMMIT.
REQ-012 COMMIT (one cycle) SHALL: set full[wb]; toggle wb; latch o_spk_cnt; pulse o_frame_done; return to IDLE.
REQ-013 i_w_run in FILL SHALL discard the partial frame, set o_err, and restart per REQ-007 into the same bank.
REQ-014 i_w_run in COMMIT SHALL be treated per REQ-006 on the following cycle only if it is still asserted; a single-cycle pulse landing in COMMIT SHALL be lost and SHALL set o_err.
REQ-015 DROP SHALL set o_err, ignore 144 i_valid cycles (a nibble counter still runs), then return to IDLE without writing or pulsing o_frame_done.
REQ-016 o_busy SHALL be 1 in FILL, COMMIT and DROP.
REQ-017 o_rd_ready SHALL equal full[rb].
REQ-018 i_rd_en SHALL load o_rd_data from bank[rb][i_rd_addr] on the next clock edge (latency 1).
REQ-019 o_rd_data SHALL hold its value when i_rd_en=0.
REQ-020 o_rd_data SHALL load 0 for i_rd_addr >= N_WORD or when o_rd_ready=0.
REQ-021 i_rd_release with o_rd_ready=1 SHALL clear full[rb] and toggle rb; with o_rd_ready=0 it SHALL be ignored.
REQ-022 A COMMIT and a release in the same cycle act on different banks, and both SHALL take effect.
REQ-023 o_err SHALL be cleared only by reset.

Reset
REQ-024 Reset SHALL put FSM=IDLE, wb=rb=0, both full flags=0, all counters=0, o_rd_data=0, o_spk_cnt=0, and o_frame_done=o_busy=o_err=o_rd_ready=0.
REQ-025 Bank contents need not be reset.
REQ-026 Reset mid-FILL SHALL abandon the frame; no o_frame_done SHALL follow.

Verification
REQ-027 Single frame: i_w_run, then 144 i_valid with i_spike=4'hF -> o_frame_done 1 cycle after the last write, o_spk_cnt=576, o_rd_ready=1, every word reads 32'hFFFFFFFF.
REQ-028 Packing: nibble sequence 1,2,...,8 per word -> word 0 reads 32'h87654321 one cycle after i_rd_en with i_rd_addr=0; i_rd_addr=18 reads 32'h0.
REQ-029 Ping-pong: two frames, no release -> both banks full; a third i_w_run -> DROP, o_err=1, no third o_frame_done. Release then reads the second frame from bank 1.
REQ-030 Restart: i_w_run after 50 i_valid -> o_err=1, and the next 144 valids commit one frame whose o_spk_cnt counts only the new data.
REQ-031 Simultaneous: i_rd_release coinciding with COMMIT -> rb toggles, full flags end as {new bank full, released bank empty}.
REQ-032 Reset asserted mid-FILL (cycle 70) -> all outputs 0; a following full frame commits normally into bank 0.
